// File: rtl/lsu_pkg.sv
// lsu_pkg: memsize encodings, LSU state type and access-legality helpers shared by the LSU, decoder and caches.
package lsu_pkg;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} lsu_state_t;

    function automatic logic size_illegal(input logic [2:0] s);
        return s == 3'b011 || s[2:1] == 2'b11;
    endfunction

    function automatic logic misaligned(input logic [2:0] s, input logic [1:0] a);
        return (s[1:0] == MEM_H[1:0] && a[0]) || (s[1:0] == MEM_W[1:0] && a != 2'b00);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte enables, replicated store data and extended load data for one word-aligned access.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  a,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_in,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);
    logic        is_b, is_h, sext;
    logic [7:0]  b;
    logic [15:0] h;

    assign is_b = size[1:0] == MEM_B[1:0];
    assign is_h = size[1:0] == MEM_H[1:0];
    assign sext = ~size[2];
    assign b    = rdata_in[{a, 3'b000} +: 8];
    assign h    = a[1] ? rdata_in[31:16] : rdata_in[15:0];

    assign be        = is_b ? 4'b0001 << a : is_h ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wdata_rep = is_b ? {4{wdata[7:0]}} : is_h ? {2{wdata[15:0]}} : wdata;
    assign rdata_ext = is_b ? {{24{sext & b[7]}}, b} : is_h ? {{16{sext & h[15]}}, h} : rdata_in;

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit running one byte-enabled transaction per request over a gnt/rvalid bus.
// Define LSU_MISALIGN_CHECK_EN to reject misaligned H/W accesses instead of ignoring low address bits.
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        memwrite,
    input  logic [2:0]  memsize,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        req_ready,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        bus_err,
    output logic        misalign,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

    lsu_state_t  state, state_n;
    logic [2:0]  size_q;
    logic [31:0] addr_q, wdata_q, rdata_q, cnt;
    logic        we_q, err_q, mis_q;
    logic        accept, illegal, mis, tmo;
    logic [3:0]  be;
    logic [31:0] wdata_rep, rdata_ext;

    lsu_align u_align (
        .size      (size_q),
        .a         (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata_in  (mem_rdata),
        .be        (be),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext)
    );

    assign accept  = state == IDLE && req_valid;
    assign illegal = size_illegal(memsize);
    assign tmo     = TIMEOUT != 0 && cnt == TMO_LAST;

`ifdef LSU_MISALIGN_CHECK_EN
    assign mis      = misaligned(memsize, addr[1:0]);
    assign misalign = resp_valid & mis_q;
`else
    assign mis      = 1'b0;
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (req_valid) state_n = (illegal || mis) ? RESP : REQ;
            REQ:     if (mem_gnt) state_n = we_q ? RESP : WAIT;
                     else if (tmo) state_n = RESP;
            WAIT:    if (mem_rvalid || tmo) state_n = RESP;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
            rdata_q <= '0;
            cnt     <= '0;
        end else begin
            if (accept) begin
                size_q  <= memsize;
                addr_q  <= addr;
                wdata_q <= wdata;
                we_q    <= memwrite;
                err_q   <= illegal;
                mis_q   <= mis;
                rdata_q <= '0;
            end
            // Data arriving on the last allowed cycle beats the timeout.
            if (state == WAIT && mem_rvalid) rdata_q <= rdata_ext;
            else if ((state == WAIT || (state == REQ && !mem_gnt)) && tmo) err_q <= 1'b1;
            if (accept) cnt <= '0;
            else if (state == REQ || state == WAIT) cnt <= cnt + 32'd1;
        end
    end

    assign req_ready  = state == IDLE;
    assign stall      = accept || state == REQ || state == WAIT;
    assign resp_valid = state == RESP;
    assign rdata      = rdata_q;
    assign bus_err    = resp_valid & err_q;
    assign mem_req    = state == REQ;
    assign mem_we     = mem_req & we_q;
    assign mem_addr   = mem_req ? {addr_q[31:2], 2'b00} : '0;
    assign mem_be     = mem_req ? be : '0;
    assign mem_wdata  = mem_req ? wdata_rep : '0;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed self-checking bench for lsu (TIMEOUT=4), covering both LSU_MISALIGN_CHECK_EN builds.
module tb_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset, req_valid, memwrite, mem_gnt, mem_rvalid;
    logic [2:0]  memsize;
    logic [31:0] addr, wdata, mem_rdata;
    logic        req_ready, stall, resp_valid, bus_err, misalign, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    int          errors = 0;
    int          checks = 0;

    lsu #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .memwrite   (memwrite),
        .memsize    (memsize),
        .addr       (addr),
        .wdata      (wdata),
        .req_ready  (req_ready),
        .stall      (stall),
        .resp_valid (resp_valid),
        .rdata      (rdata),
        .bus_err    (bus_err),
        .misalign   (misalign),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1;
        memwrite  = we;
        memsize   = sz;
        addr      = a;
        wdata     = d;
        step();
        req_valid = 1'b0;
        memwrite  = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        checks++; if ({stall, resp_valid, bus_err, misalign, mem_req, mem_we} !== 6'b0) begin errors++; $display("FAIL reset_flags: got %b want 000000", {stall, resp_valid, bus_err, misalign, mem_req, mem_we}); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        checks++; if ({mem_addr, mem_be, mem_wdata} !== 68'h0) begin errors++; $display("FAIL reset_mem_bus: got %h want 0", {mem_addr, mem_be, mem_wdata}); end
    endtask

    task automatic test_store(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] exp_be, input logic [31:0] exp_wd);
        req_valid = 1'b1; memwrite = 1'b1; memsize = sz; addr = a; wdata = d;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL st_accept_stall @%h: got %b want 1", a, stall); end
        step();
        req_valid = 1'b0; memwrite = 1'b0;
        checks++; if ({mem_req, mem_we, stall} !== 3'b111) begin errors++; $display("FAIL st_req_flags @%h: got %b want 111", a, {mem_req, mem_we, stall}); end
        checks++; if (mem_addr !== (a & 32'hFFFF_FFFC)) begin errors++; $display("FAIL st_addr @%h: got %h want %h", a, mem_addr, a & 32'hFFFF_FFFC); end
        checks++; if (mem_be !== exp_be) begin errors++; $display("FAIL st_be @%h: got %b want %b", a, mem_be, exp_be); end
        checks++; if (mem_wdata !== exp_wd) begin errors++; $display("FAIL st_wdata @%h: got %h want %h", a, mem_wdata, exp_wd); end
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        req_valid = 1'b1;
        #1;
        checks++; if ({resp_valid, stall, req_ready, bus_err} !== 4'b1000) begin errors++; $display("FAIL st_resp_flags @%h: got %b want 1000", a, {resp_valid, stall, req_ready, bus_err}); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL st_rdata @%h: got %h want 0", a, rdata); end
        req_valid = 1'b0;
        step();
        checks++; if ({resp_valid, req_ready, mem_req} !== 3'b010) begin errors++; $display("FAIL st_idle @%h: got %b want 010", a, {resp_valid, req_ready, mem_req}); end
    endtask

    task automatic test_load(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] rd,
                             input logic [3:0] exp_be, input logic [31:0] exp_rd);
        issue(1'b0, sz, a, 32'hFFFF_FFFF);
        checks++; if ({mem_req, mem_we} !== 2'b10) begin errors++; $display("FAIL ld_req_flags @%h: got %b want 10", a, {mem_req, mem_we}); end
        checks++; if (mem_addr !== (a & 32'hFFFF_FFFC)) begin errors++; $display("FAIL ld_addr @%h: got %h want %h", a, mem_addr, a & 32'hFFFF_FFFC); end
        checks++; if (mem_be !== exp_be) begin errors++; $display("FAIL ld_be @%h: got %b want %b", a, mem_be, exp_be); end
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
        step();
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        checks++; if ({mem_req, stall, resp_valid} !== 3'b010) begin errors++; $display("FAIL ld_wait_flags @%h: got %b want 010", a, {mem_req, stall, resp_valid}); end
        mem_rvalid = 1'b1; mem_rdata = rd;
        step();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        checks++; if ({resp_valid, bus_err, stall} !== 3'b100) begin errors++; $display("FAIL ld_resp_flags @%h: got %b want 100", a, {resp_valid, bus_err, stall}); end
        checks++; if (rdata !== exp_rd) begin errors++; $display("FAIL ld_rdata @%h size %b: got %h want %h", a, sz, rdata, exp_rd); end
        step();
    endtask

    task automatic test_timeout();
        issue(1'b0, MEM_W, 32'h200, 32'h0);
        for (int i = 0; i < 4; i++) begin
            checks++; if ({mem_req, resp_valid} !== 2'b10) begin errors++; $display("FAIL tmo_req_cycle%0d: got %b want 10", i, {mem_req, resp_valid}); end
            step();
        end
        checks++; if ({resp_valid, bus_err, mem_req, stall} !== 4'b1100) begin errors++; $display("FAIL tmo_resp_flags: got %b want 1100", {resp_valid, bus_err, mem_req, stall}); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL tmo_rdata: got %h want 0", rdata); end
        step();
        checks++; if ({mem_req, req_ready, resp_valid} !== 3'b010) begin errors++; $display("FAIL tmo_after: got %b want 010", {mem_req, req_ready, resp_valid}); end
    endtask

    task automatic test_timeout_data_wins();
        issue(1'b0, MEM_W, 32'h300, 32'h0);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        step();
        step();
        checks++; if ({resp_valid, stall} !== 2'b01) begin errors++; $display("FAIL tdw_wait: got %b want 01", {resp_valid, stall}); end
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        step();
        mem_rvalid = 1'b0;
        checks++; if ({resp_valid, bus_err} !== 2'b10) begin errors++; $display("FAIL tdw_flags: got %b want 10", {resp_valid, bus_err}); end
        checks++; if (rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL tdw_rdata: got %h want cafef00d", rdata); end
        step();
    endtask

    task automatic test_illegal(input logic [2:0] sz);
        issue(1'b0, sz, 32'h40, 32'h0);
        checks++; if ({resp_valid, bus_err, mem_req, misalign} !== 4'b1100) begin errors++; $display("FAIL illegal_%b: got %b want 1100", sz, {resp_valid, bus_err, mem_req, misalign}); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL illegal_rdata_%b: got %h want 0", sz, rdata); end
        step();
        checks++; if ({req_ready, resp_valid} !== 2'b10) begin errors++; $display("FAIL illegal_idle_%b: got %b want 10", sz, {req_ready, resp_valid}); end
    endtask

    task automatic test_misalign();
        issue(1'b0, MEM_W, 32'h101, 32'h0);
`ifdef LSU_MISALIGN_CHECK_EN
        checks++; if ({resp_valid, misalign, bus_err, mem_req} !== 4'b1100) begin errors++; $display("FAIL mis_resp: got %b want 1100", {resp_valid, misalign, bus_err, mem_req}); end
        step();
        checks++; if ({mem_req, req_ready, resp_valid} !== 3'b010) begin errors++; $display("FAIL mis_after: got %b want 010", {mem_req, req_ready, resp_valid}); end
`else
        checks++; if ({mem_req, mem_be} !== 5'b11111) begin errors++; $display("FAIL nomis_req: got %b want 11111", {mem_req, mem_be}); end
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL nomis_addr: got %h want 00000100", mem_addr); end
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h55AA_55AA;
        step();
        mem_rvalid = 1'b0;
        checks++; if ({resp_valid, misalign, bus_err} !== 3'b100) begin errors++; $display("FAIL nomis_resp: got %b want 100", {resp_valid, misalign, bus_err}); end
        checks++; if (rdata !== 32'h55AA_55AA) begin errors++; $display("FAIL nomis_rdata: got %h want 55aa55aa", rdata); end
        step();
`endif
    endtask

    task automatic test_reset_mid();
        issue(1'b0, MEM_W, 32'h400, 32'h0);
        reset = 1'b1;
        #1;
        checks++; if ({mem_req, stall, req_ready} !== 3'b001) begin errors++; $display("FAIL rst_req: got %b want 001", {mem_req, stall, req_ready}); end
        reset = 1'b0;
        step();
        issue(1'b0, MEM_W, 32'h400, 32'h0);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_wait_stall: got %b want 1", stall); end
        reset = 1'b1;
        #1;
        checks++; if ({mem_req, stall, req_ready} !== 3'b001) begin errors++; $display("FAIL rst_wait: got %b want 001", {mem_req, stall, req_ready}); end
        reset = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        mem_rvalid = 1'b0;
        checks++; if ({resp_valid, req_ready, stall} !== 3'b010) begin errors++; $display("FAIL rst_rvalid1: got %b want 010", {resp_valid, req_ready, stall}); end
        step();
        checks++; if ({resp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL rst_rvalid2: got %b want 01", {resp_valid, req_ready}); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", rdata); end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; memwrite = 1'b0; memsize = MEM_B;
        addr = '0; wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #2;
        test_reset();
        reset = 1'b0;
        step();
        test_store(MEM_W, 32'h100, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
        test_store(MEM_H, 32'h102, 32'h0000_1234, 4'b1100, 32'h1234_1234);
        test_store(MEM_H, 32'h100, 32'hFFFF_5678, 4'b0011, 32'h5678_5678);
        test_store(MEM_B, 32'h101, 32'h0000_00A5, 4'b0010, 32'hA5A5_A5A5);
        test_load(MEM_B,  32'h103, 32'h8012_3456, 4'b1000, 32'hFFFF_FF80);
        test_load(MEM_BU, 32'h103, 32'h8012_3456, 4'b1000, 32'h0000_0080);
        test_load(MEM_B,  32'h101, 32'h0000_7F00, 4'b0010, 32'h0000_007F);
        test_load(MEM_HU, 32'h102, 32'hABCD_0000, 4'b1100, 32'h0000_ABCD);
        test_load(MEM_H,  32'h100, 32'h1234_F00F, 4'b0011, 32'hFFFF_F00F);
        test_load(MEM_W,  32'h204, 32'h89AB_CDEF, 4'b1111, 32'h89AB_CDEF);
        test_timeout();
        test_timeout_data_wins();
        test_illegal(3'b011);
        test_illegal(3'b111);
        test_misalign();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
